// File: rtl/adder_accumulate_sequencer.sv
// rtl/adder_accumulate_sequencer.sv - operand sequencer that accumulates a frame through an external 4-bit adder
module adder_accumulate_sequencer #(
  parameter int SETTLE_CYCLES = 8,
  parameter int COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_data,
  input  logic               in_last,
  output logic [3:0]         add_a,
  output logic [3:0]         add_b,
  input  logic [3:0]         add_sum,
  input  logic               add_carryout,
  input  logic               add_overflow,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_sum,
  output logic               out_carry,
  output logic               out_overflow,
  output logic [COUNT_W-1:0] out_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [3:0]         acc_q, acc_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               last_q, last_d;
  logic [7:0]         settle_q, settle_d;
  logic [3:0]         add_a_q, add_a_d;
  logic [3:0]         add_b_q, add_b_d;
  // Holds in_ready low until the first edge after reset release.
  logic               live_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    settle_d = settle_q;
    add_a_d  = add_a_q;
    add_b_d  = add_b_q;
    case (state_q)
      IDLE: begin
        if (in_valid && live_q) begin
          add_a_d  = acc_q;
          add_b_d  = in_data;
          last_d   = in_last;
          settle_d = SETTLE_INIT;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q != 8'd0) begin
          settle_d = settle_q - 8'd1;
        end else begin
          acc_d   = add_sum;
          carry_d = carry_q | add_carryout;
          ovf_d   = ovf_q | add_overflow;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + COUNT_W'(1);
          state_d = last_q ? DONE : IDLE;
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_d   = 4'd0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= 4'd0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      settle_q <= 8'd0;
      add_a_q  <= 4'd0;
      add_b_q  <= 4'd0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      settle_q <= settle_d;
      add_a_q  <= add_a_d;
      add_b_q  <= add_b_d;
      live_q   <= 1'b1;
    end
  end

  assign in_ready     = (state_q == IDLE) && live_q;
  assign out_valid    = (state_q == DONE);
  assign add_a        = add_a_q;
  assign add_b        = add_b_q;
  assign out_sum      = acc_q;
  assign out_carry    = carry_q;
  assign out_overflow = ovf_q;
  assign out_count    = cnt_q;

endmodule

// File: tb/tb_adder_accumulate_sequencer.sv
// tb/tb_adder_accumulate_sequencer.sv - scoreboard bench for adder_accumulate_sequencer
module tb_adder_accumulate_sequencer;

  localparam int S = 8;

  typedef struct packed {
    logic [3:0] sum;
    logic       c;
    logic       o;
    logic [7:0] cnt;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, in_last, out_valid, out_ready;
  logic [3:0] in_data, add_a, add_b, add_sum, out_sum;
  logic       add_carryout, add_overflow, out_carry, out_overflow;
  logic [7:0] out_count;

  logic       in_valid1, in_ready1, in_last1, out_valid1, out_ready1;
  logic [3:0] in_data1, add_a1, add_b1, add_sum1, out_sum1;
  logic       add_carryout1, add_overflow1, out_carry1, out_overflow1;
  logic [1:0] out_count1;

  logic corrupt, inj_c, inj_o;

  adder_accumulate_sequencer #(.SETTLE_CYCLES(S), .COUNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_carryout(add_carryout), .add_overflow(add_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carry(out_carry), .out_overflow(out_overflow), .out_count(out_count)
  );

  adder_accumulate_sequencer #(.SETTLE_CYCLES(1), .COUNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_last(in_last1), .add_a(add_a1), .add_b(add_b1),
    .add_sum(add_sum1), .add_carryout(add_carryout1), .add_overflow(add_overflow1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
    .out_carry(out_carry1), .out_overflow(out_overflow1), .out_count(out_count1)
  );

  // Behavioural adders standing in for the gate-level 4-bit adder.
  logic [4:0] t0, t1;
  always_comb begin
    t0           = {1'b0, add_a} + {1'b0, add_b};
    add_sum      = corrupt ? 4'hF : t0[3:0];
    add_carryout = t0[4] | inj_c;
    add_overflow = ((add_a[3] == add_b[3]) && (t0[3] != add_a[3])) | inj_o;
    t1            = {1'b0, add_a1} + {1'b0, add_b1};
    add_sum1      = t1[3:0];
    add_carryout1 = t1[4];
    add_overflow1 = (add_a1[3] == add_b1[3]) && (t1[3] != add_a1[3]);
  end

  int compared = 0;
  int mismatched = 0;
  res_t q0[$];
  res_t q1[$];

  logic [3:0] m_acc;
  logic       m_c, m_o;
  logic [7:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_acc = 4'd0; m_c = 1'b0; m_o = 1'b0; m_cnt = 8'd0;
  endtask

  task automatic model_add(input logic [3:0] d, input logic ic, input logic io);
    logic [4:0] t;
    t = {1'b0, m_acc} + {1'b0, d};
    m_c = m_c | t[4] | ic;
    m_o = m_o | ((m_acc[3] == d[3]) && (t[3] != m_acc[3])) | io;
    m_acc = t[3:0];
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
  endtask

  task automatic send(input logic [3:0] d, input logic last, input logic ic,
                      input logic io, input logic cmode);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    inj_c = ic; inj_o = io; corrupt = 1'b0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_wait", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("add_a", 32'(add_a), 32'(m_acc));
    chk("add_b", 32'(add_b), 32'(d));
    corrupt = cmode;
    model_add(d, ic, io);
    for (int j = 1; j <= S; j++) begin
      @(posedge clk); #1;
      if (j == S - 1) begin
        chk("settle_in_ready", 32'(in_ready), 32'd0);
        chk("settle_out_valid", 32'(out_valid), 32'd0);
        corrupt = 1'b0;
      end
    end
    if (last) begin
      chk("capture_out_valid", 32'(out_valid), 32'd1);
      q0.push_back('{sum: m_acc, c: m_c, o: m_o, cnt: m_cnt});
      model_clear();
    end else begin
      chk("capture_in_ready", 32'(in_ready), 32'd1);
      chk("capture_no_valid", 32'(out_valid), 32'd0);
    end
    corrupt = cmode;
  endtask

  task automatic take_result();
    res_t e;
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("result_valid", 32'(out_valid), 32'd1);
    chk("sb_pending", 32'(q0.size() != 0), 32'd1);
    if (q0.size() != 0) begin
      e = q0.pop_front();
      chk("out_sum", 32'(out_sum), 32'(e.sum));
      chk("out_carry", 32'(out_carry), 32'(e.c));
      chk("out_overflow", 32'(out_overflow), 32'(e.o));
      chk("out_count", 32'(out_count), 32'(e.cnt));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; corrupt = 1'b0; inj_c = 1'b0; inj_o = 1'b0;
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_count_clr", 32'(out_count), 32'd0);
  endtask

  // Back-to-back ones into the SETTLE_CYCLES=1 instance: accept, capture, accept, ...
  task automatic burst1(input int n);
    res_t e;
    in_valid1 = 1'b1; in_data1 = 4'd1;
    for (int i = 0; i < 2 * n; i++) begin
      in_last1 = (i == 2 * n - 2);
      @(posedge clk); #1;
      if (i < 2 * n - 1) chk("b_in_ready", 32'(in_ready1), 32'((i % 2) == 1));
    end
    in_valid1 = 1'b0; in_last1 = 1'b0;
    q1.push_back('{sum: 4'(n), c: 1'b0, o: 1'b0, cnt: (n > 3) ? 8'd3 : 8'(n)});
    chk("b_out_valid", 32'(out_valid1), 32'd1);
    e = q1.pop_front();
    chk("b_out_sum", 32'(out_sum1), 32'(e.sum));
    chk("b_out_count", 32'(out_count1), 32'(e.cnt));
    chk("b_flags", 32'({out_carry1, out_overflow1}), 32'({e.c, e.o}));
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    chk("b_post_ready", 32'(in_ready1), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
    in_valid1 = 0; in_data1 = 0; in_last1 = 0; out_ready1 = 0;
    corrupt = 0; inj_c = 0; inj_o = 0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_flags", 32'({out_carry, out_overflow}), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_add_ab", 32'({add_a, add_b}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    send(4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    send(4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    take_result();

    send(4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    send(4'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    take_result();

    send(4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    send(4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    send(4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 4'd9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_sum", 32'(out_sum), 32'(q0[0].sum));
      chk("bp_out_count", 32'(out_count), 32'(q0[0].cnt));
    end
    in_valid = 1'b0;
    take_result();
    send(4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    take_result();

    send(4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 4'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_sum", 32'(out_sum), 32'd0);
    chk("mid_rst_out_count", 32'(out_count), 32'd0);
    chk("mid_rst_add_ab", 32'({add_a, add_b}), 32'd0);
    chk("mid_rst_handshake", 32'({in_ready, out_valid}), 32'd0);
    model_clear();
    @(negedge clk); rst_n = 1'b1;
    send(4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    take_result();

    burst1(3);
    burst1(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
